// File: rtl/micro_tile_switch.sv
// Shares one 8-bit pad bus across N_TILES micro tiles.
// A select change runs drain -> gate -> reset-hold -> run, so no tile ever sees a truncated clock.
module micro_tile_switch #(
   parameter int N_TILES     = 4,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int RST_HOLD    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SEL_W-1:0]       sel_in,
   input  logic [7:0]             ui_in,
   output logic [7:0]             uo_out,
   output logic [N_TILES-1:0]     tile_clk_en,
   output logic [N_TILES-1:0]     tile_rst_n,
   output logic [8*N_TILES-1:0]   tile_ui_in,
   input  logic [8*N_TILES-1:0]   tile_uo_out,
   output logic [SEL_W-1:0]       active_sel,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_RUN,
      S_DRAIN,
      S_GATE,
      S_HOLD,
      S_PARK
   } state_t;

   state_t                              state;
   logic [7:0]                          hold_cnt;
   logic [SYNC_STAGES-1:0][SEL_W-1:0]   sync_q;
   logic [SEL_W-1:0]                    sel_sync;
   logic                                sel_change;
   logic                                active_valid;
   logic                                ui_live;
   logic [7:0]                          run_data;

   function automatic logic [N_TILES-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [N_TILES-1:0] v;
      v = '0;
      for (int i = 0; i < N_TILES; i++) begin
         v[i] = (int'(s) == i);
      end
      return v;
   endfunction

   assign sel_sync     = sync_q[SYNC_STAGES-1];
   assign sel_change   = (sel_sync != active_sel);
   assign active_valid = (int'(active_sel) < N_TILES);
   assign ui_live      = (state == S_HOLD) || (state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sel_in};
      end
   end

   always_comb begin
      run_data = '0;
      for (int i = 0; i < N_TILES; i++) begin
         if (int'(active_sel) == i) begin
            run_data = tile_uo_out[8*i +: 8];
         end
      end
   end

   // Input gating depends only on registered state, so the pad path stays purely combinational.
   always_comb begin
      tile_ui_in = '0;
      for (int i = 0; i < N_TILES; i++) begin
         if (ui_live && (int'(active_sel) == i)) begin
            tile_ui_in[8*i +: 8] = ui_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_HOLD;
         hold_cnt    <= '0;
         active_sel  <= '0;
         tile_clk_en <= N_TILES'(1);
         tile_rst_n  <= '0;
         uo_out      <= '0;
         busy        <= 1'b1;
      end else begin
         uo_out <= '0;
         case (state)
            S_RUN: begin
               if (sel_change) begin
                  state      <= S_DRAIN;
                  tile_rst_n <= '0;
                  busy       <= 1'b1;
               end else begin
                  uo_out <= run_data;
               end
            end
            // The outgoing tile keeps its clock for one more edge so it sees reset asserted.
            S_DRAIN: begin
               state       <= S_GATE;
               active_sel  <= sel_sync;
               tile_clk_en <= '0;
               tile_rst_n  <= '0;
            end
            S_GATE: begin
               if (active_valid) begin
                  state       <= S_HOLD;
                  hold_cnt    <= '0;
                  tile_clk_en <= onehot(active_sel);
               end else begin
                  state <= S_PARK;
                  busy  <= 1'b0;
               end
            end
            S_HOLD: begin
               if (hold_cnt == 8'(RST_HOLD - 1)) begin
                  state      <= S_RUN;
                  tile_rst_n <= onehot(active_sel);
                  busy       <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            S_PARK: begin
               if (sel_change) begin
                  state      <= S_GATE;
                  active_sel <= sel_sync;
                  busy       <= 1'b1;
               end
            end
            default: begin
               state       <= S_GATE;
               active_sel  <= sel_sync;
               tile_clk_en <= '0;
               tile_rst_n  <= '0;
               busy        <= 1'b1;
            end
         endcase
      end
   end

endmodule
